// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings and phase-offset helper for the multi-channel PWM fader
package pwm_pkg;
    localparam logic MODE_TRI = 1'b0;
    localparam logic MODE_SAW = 1'b1;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Starting duty of channel i, evenly spread across [dmin, dmax) to stagger the fade wave.
    function automatic int phase_offset(input int i, input int nch, input int dmin, input int dmax);
        return dmin + (i * (dmax - dmin)) / nch;
    endfunction
endpackage

// File: rtl/pwm_fade_channel.sv
// pwm_fade_channel: one fading PWM channel (duty/dir state, fade update, registered compare)
//   clk, rst_n : clock, async active-low reset
//   en         : 1 = compare active, 0 = output forced low
//   upd        : one-cycle strobe, advances the fade by one step
//   mode       : MODE_TRI / MODE_SAW, sampled only on upd
//   cnt        : shared period counter
//   pwm        : registered PWM output
module pwm_fade_channel
    import pwm_pkg::*;
#(
    parameter int CW        = 16,
    parameter int DUTY_MIN  = 500,
    parameter int DUTY_MAX  = 35_000,
    parameter int INIT_DUTY = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          upd,
    input  logic          mode,
    input  logic [CW-1:0] cnt,
    output logic          pwm
);
    localparam logic [CW-1:0] DMIN = CW'(DUTY_MIN);
    localparam logic [CW-1:0] DMAX = CW'(DUTY_MAX);
    localparam logic [CW-1:0] D0   = CW'(INIT_DUTY);

    logic [CW-1:0] duty, nxt_duty;
    logic          dir, nxt_dir;
    logic          at_max, at_min;

    assign at_max = duty >= DMAX;
    assign at_min = duty <= DMIN;

    // Out-of-range duty is clamped first; otherwise step per mode with no dwell at the ends.
    always_comb begin
        nxt_duty = duty;
        nxt_dir  = dir;
        if (duty < DMIN || duty > DMAX) begin
            nxt_duty = duty < DMIN ? DMIN : DMAX;
            nxt_dir  = mode == MODE_SAW ? DIR_UP : dir;
        end else if (mode == MODE_SAW) begin
            nxt_duty = at_max ? DMIN : duty + CW'(1);
            nxt_dir  = DIR_UP;
        end else if (dir == DIR_UP) begin
            nxt_duty = at_max ? duty - CW'(1) : duty + CW'(1);
            nxt_dir  = at_max ? DIR_DOWN : DIR_UP;
        end else begin
            nxt_duty = at_min ? duty + CW'(1) : duty - CW'(1);
            nxt_dir  = at_min ? DIR_UP : DIR_DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= D0;
            dir  <= DIR_UP;
            pwm  <= 1'b0;
        end else begin
            pwm <= en && (cnt < duty);
            if (upd) begin
                duty <= nxt_duty;
                dir  <= nxt_dir;
            end
        end
    end
endmodule

// File: rtl/pwm_fader_multi.sv
// pwm_fader_multi: NCH-channel phase-staggered PWM LED fader sharing one period counter
//   clk, rst_n  : clock, async active-low reset
//   en          : 1 = run, 0 = freeze counter/fade and force outputs low
//   mode        : 0 = triangle fade, 1 = sawtooth fade
//   pwm         : registered PWM outputs, one per channel
//   period_tick : one-cycle pulse per period wrap
//   duty_upd    : one-cycle pulse per duty update
//   PWM_CENTER_ALIGNED_EN : when defined, up/down counter with centred pulses
module pwm_fader_multi
    import pwm_pkg::*;
#(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int NCH          = 8,
    parameter int CW           = 16,
    parameter int PERIOD       = 50_000,
    parameter int DUTY_MIN     = 500,
    parameter int DUTY_MAX     = 35_000,
    parameter int STEP_PERIODS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           mode,
    output logic [NCH-1:0] pwm,
    output logic           period_tick,
    output logic           duty_upd
);
    localparam logic [CW-1:0] LAST      = CW'(PERIOD - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_PERIODS - 1);

    if (!(DUTY_MIN < DUTY_MAX && DUTY_MAX <= PERIOD && PERIOD >= 2 && CLK_FREQ >= PERIOD)) begin : g_bad_params
        $error("pwm_fader_multi: inconsistent parameters");
    end

    logic [CW-1:0] cnt, step;
    logic          wrap, upd;

`ifdef PWM_CENTER_ALIGNED_EN
    logic cdir;

    // Wrap is the step back into cnt==0; with PERIOD==2 the counter just toggles 0,1.
    assign wrap = en && (PERIOD == 2 ? cnt == LAST : (cdir == DIR_DOWN && cnt == CW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            cdir <= DIR_UP;
        end else if (en) begin
            if (cdir == DIR_UP) begin
                cnt  <= cnt == LAST ? (PERIOD == 2 ? '0 : cnt - CW'(1)) : cnt + CW'(1);
                cdir <= (cnt == LAST && PERIOD != 2) ? DIR_DOWN : DIR_UP;
            end else begin
                cnt  <= cnt - CW'(1);
                cdir <= cnt == CW'(1) ? DIR_UP : DIR_DOWN;
            end
        end
    end
`else
    assign wrap = en && cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + CW'(1);
    end
`endif

    // Duties change on the same edge cnt returns to 0, so each period sees one stable duty.
    assign upd = wrap && step == STEP_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step        <= '0;
            period_tick <= 1'b0;
            duty_upd    <= 1'b0;
        end else begin
            step        <= upd ? '0 : (wrap ? step + CW'(1) : step);
            period_tick <= wrap;
            duty_upd    <= upd;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_fade_channel #(
            .CW       (CW),
            .DUTY_MIN (DUTY_MIN),
            .DUTY_MAX (DUTY_MAX),
            .INIT_DUTY(phase_offset(i, NCH, DUTY_MIN, DUTY_MAX))
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .upd  (upd),
            .mode (mode),
            .cnt  (cnt),
            .pwm  (pwm[i])
        );
    end
endmodule

// File: doc/pwm_fader_multi.md
Name: pwm_fader_multi

Overview:
- Multi-channel PWM LED fader. Parametrised successor to the single-channel fade controller.
- One shared period counter drives NCH compare channels. Each channel ramps its own duty between programmable bounds, in triangle or sawtooth mode.
- Channel start points are phase-staggered, which gives "breathing wave" effects on the LED bank.
- Sits between the board clock/reset and the LED pins; no bus interface.

Parameters:
- CLK_FREQ, 25_000_000, input clock in Hz (documentation/derivation only)
- NCH, 8, number of PWM channels (1..32)
- CW, 16, counter/duty width in bits
- PERIOD, 50_000, PWM period in clk cycles (2..2^CW-1); 500 Hz at default clock
- DUTY_MIN, 500, lower fade bound in counts
- DUTY_MAX, 35_000, upper fade bound in counts (DUTY_MIN < DUTY_MAX <= PERIOD)
- STEP_PERIODS, 1, PWM periods between duty updates (1..2^CW-1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  1 = run; 0 = freeze counter and fade, force outputs low
- mode  input  1  0 = triangle fade, 1 = sawtooth fade
- pwm  output  NCH  registered PWM outputs
- period_tick  output  1  one-cycle pulse on each period wrap
- duty_upd  output  1  one-cycle pulse on each cycle where duties update

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, step counter=0, pwm=0, period_tick=0, duty_upd=0.
  - duty[i] = DUTY_MIN + (i*(DUTY_MAX-DUTY_MIN))/NCH, computed at elaboration with integer truncation.
  - dir[i] = up.
- Period counter:
  - When en=1, cnt increments each clk.
  - At cnt==PERIOD-1 it wraps to 0 and period_tick=1 in the following cycle.
- Compare:
  - pwm[i] <= en && (cnt < duty[i]). One clk latency from cnt.
  - duty=0 gives constant low. duty>=PERIOD gives constant high.
- Update tick:
  - The step counter counts period wraps.
  - On the wrap where step==STEP_PERIODS-1, step resets and every channel updates in that same cycle; duty_upd pulses once.
  - Duties only change at cnt wrap, so no glitch within a period.
- Triangle update, per channel:
  - dir up, duty>=DUTY_MAX: dir<=down, duty<=duty-1.
  - dir up, otherwise: duty<=duty+1.
  - dir down, duty<=DUTY_MIN: dir<=up, duty<=duty+1.
  - dir down, otherwise: duty<=duty-1.
  - No dwell at the ends.
- Sawtooth update:
  - duty>=DUTY_MAX: duty<=DUTY_MIN.
  - Otherwise: duty<=duty+1.
  - dir is forced to up.
- Mode change:
  - Sampled only at update ticks; no effect mid-period.
  - Switching to triangle resumes with dir=up.
- Out-of-range duty (defensive): clamp into [DUTY_MIN, DUTY_MAX] at the next update.
- en=0:
  - cnt, step, duty and dir hold; pwm<=0 next cycle; pulses suppressed.
  - On en=1, resume from the held cnt.
- Reset mid-period: all state returns to reset values immediately; outputs low while rst_n=0.
- Arithmetic:
  - Counters are CW bits unsigned.
  - Phase-offset products are computed at elaboration in 32-bit integer.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined:
  - cnt counts 0..PERIOD-1, then down PERIOD-1..0 (up/down counter, direction flag reset to up).
  - pwm[i] = cnt < duty[i], so pulses are centred. Effective period is 2*PERIOD-2 clks.
  - period_tick and the update tick fire at the cnt==0 turnaround.
- Undefined: edge-aligned sawtooth counter as described above.

Decomposition:
- pwm_pkg holds:
  - mode encoding constants MODE_TRI=1'b0, MODE_SAW=1'b1;
  - dir encoding DIR_UP=1'b1, DIR_DOWN=1'b0;
  - a function computing the initial phase offset for channel i.
- Sub-module pwm_fade_channel, instantiated NCH times in a generate loop:
  - holds one duty/dir pair, update logic and compare flop;
  - inputs: cnt, upd strobe, mode, en.
- The top level owns cnt, the step counter and the pulses.

Test Plan:
- Bench params for all scenarios: PERIOD=10, NCH=2, DUTY_MIN=1, DUTY_MAX=7, STEP_PERIODS=1.
- Reset values: rst_n low 5 clks -> pwm=00, period_tick=0, duty[0]=1, duty[1]=4; first period ch0 high 1 clk, ch1 high 4 clks.
- Triangle: mode=0, 14 periods -> ch0 high-time per period 1,2,3,4,5,6,7,6,5,4,3,2,1,2; period_tick every 10 clks.
- Sawtooth: mode=1 from reset -> ch0 high-time 1..7,1,2; ch1 4,5,6,7,1,2.
- en gating: en=0 at cnt=5 for 20 clks -> pwm=0 after 1 clk, no pulses; en=1 -> cnt resumes at 5, duty unchanged.
- Async reset mid-period: rst_n low at cnt=6 while mid-fade (duty[0]=5) -> pwm=0 immediately; on release, duty[0]=1, cnt=0.
- STEP_PERIODS=3 rerun: duty_upd every 30 clks; ch0 duty steps 1->2 only after the third wrap.
